// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with a shared period counter,
// edge- or center-aligned counting and double-buffered period/duty registers.
module pwm_multi #(
  parameter int CBITS = 10,
  parameter int NCH   = 4,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             center_mode,
  input  logic             period_we,
  input  logic [CBITS-1:0] period_wdata,
  input  logic             duty_we,
  input  logic [SELW-1:0]  duty_sel,
  input  logic [CBITS-1:0] duty_wdata,
  input  logic [NCH-1:0]   polarity,
  output logic [NCH-1:0]   pulse,
  output logic             cycle_start
);

  localparam logic [CBITS-1:0] ONE = CBITS'(1);

  logic [CBITS-1:0] cnt;
  logic [CBITS-1:0] cnt_next;
  logic             dir_down;
  logic             dir_down_next;
  logic             center_act;
  logic             update;
  logic [CBITS-1:0] period_sh;
  logic [CBITS-1:0] period_act;
  logic [CBITS-1:0] duty_sh  [NCH];
  logic [CBITS-1:0] duty_act [NCH];
  logic [NCH-1:0]   pulse_next;

  // Next counter value and direction; a zero next value marks the start of a new cycle.
  always_comb begin
    cnt_next      = '0;
    dir_down_next = 1'b0;
    if (en) begin
      // period_act = 0 has no room for a down slope, so it always counts edge-style.
      if (center_act && (period_act != '0)) begin
        if (!dir_down) begin
          if (cnt == period_act) begin
            cnt_next      = period_act - ONE;
            // With period 1 the down slope is empty and the cycle wraps straight to 0.
            dir_down_next = (period_act != ONE);
          end else begin
            cnt_next = cnt + ONE;
          end
        end else begin
          cnt_next      = cnt - ONE;
          dir_down_next = (cnt != ONE);
        end
      end else begin
        cnt_next = (cnt == period_act) ? '0 : cnt + ONE;
      end
    end
  end

  assign update = en && (cnt_next == '0);

  // Counter, direction and the active period/mode, reloaded only at cycle boundaries or while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      dir_down   <= 1'b0;
      period_act <= '1;
      center_act <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      dir_down <= dir_down_next;
      if (!en || update) begin
        period_act <= period_sh;
        center_act <= center_mode;
      end
    end
  end

  // Period shadow register, writable at any time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_sh <= '1;
    end else if (period_we) begin
      period_sh <= period_wdata;
    end
  end

  // Per-channel duty shadow/active pair and comparator. Channel indices only
  // run up to NCH-1, so a select value beyond that matches no channel.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      // Duty shadow is written by software; active copy follows it at cycle boundaries.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          duty_sh[gi]  <= '0;
          duty_act[gi] <= '0;
        end else begin
          if (duty_we && (duty_sel == SELW'(gi))) begin
            duty_sh[gi] <= duty_wdata;
          end
          if (!en || update) begin
            duty_act[gi] <= duty_sh[gi];
          end
        end
      end

      assign pulse_next[gi] = en ? ((cnt < duty_act[gi]) ^ polarity[gi]) : polarity[gi];
    end
  endgenerate

  // Registered outputs, one clock behind the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse       <= '0;
      cycle_start <= 1'b0;
    end else begin
      pulse       <= pulse_next;
      cycle_start <= en && (cnt == '0);
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed checks of pwm_multi with CBITS=4, NCH=2.
// Waveforms are captured as bit vectors (bit k = sample k after an edge)
// and compared against hand-computed patterns.
module tb_pwm_multi;

  localparam int CBITS = 4;
  localparam int NCH   = 2;
  localparam int SELW  = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             center_mode;
  logic             period_we;
  logic [CBITS-1:0] period_wdata;
  logic             duty_we;
  logic [SELW-1:0]  duty_sel;
  logic [CBITS-1:0] duty_wdata;
  logic [NCH-1:0]   polarity;
  logic [NCH-1:0]   pulse;
  logic             cycle_start;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] cap_p0;
  logic [63:0] cap_p1;
  logic [63:0] cap_cs;

  pwm_multi #(.CBITS(CBITS), .NCH(NCH), .SELW(SELW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .center_mode (center_mode),
    .period_we   (period_we),
    .period_wdata(period_wdata),
    .duty_we     (duty_we),
    .duty_sel    (duty_sel),
    .duty_wdata  (duty_wdata),
    .polarity    (polarity),
    .pulse       (pulse),
    .cycle_start (cycle_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Capture n consecutive samples of pulse[0], pulse[1] and cycle_start.
  task automatic capture(input int n);
    cap_p0 = '0;
    cap_p1 = '0;
    cap_cs = '0;
    for (int k = 0; k < n; k++) begin
      tick();
      cap_p0[k] = pulse[0];
      cap_p1[k] = pulse[1];
      cap_cs[k] = cycle_start;
    end
  endtask

  task automatic wr_duty(input logic [SELW-1:0] sel, input logic [CBITS-1:0] val);
    duty_we    = 1'b1;
    duty_sel   = sel;
    duty_wdata = val;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; center_mode = 1'b0;
    period_we = 1'b0; period_wdata = '0;
    duty_we = 1'b0; duty_sel = '0; duty_wdata = '0;
    polarity = 2'b00;
    tick(); tick();
    rst = 1'b0;
    check("reset_pulse", 64'(pulse), 64'h0);
    check("reset_cs", 64'(cycle_start), 64'h0);

    // 1: edge mode, period 9, duty ch0 3
    period_we = 1'b1; period_wdata = 4'd9;
    capture(1);
    period_we = 1'b0;
    wr_duty(1'b0, 4'd3);
    capture(1);
    duty_we = 1'b0;
    capture(1);
    en = 1'b1;
    capture(20);
    check("s1_p0", cap_p0, 64'h1C07);
    check("s1_cs", cap_cs, 64'h0401);
    check("s1_p1", cap_p1, 64'h0);

    // 2: duty change mid-cycle (cnt=5) applies next cycle
    capture(5);
    wr_duty(1'b0, 4'd7);
    capture(1);
    duty_we = 1'b0;
    check("s2_cnt5", cap_p0, 64'h0);
    capture(4);
    check("s2_rest_old", cap_p0, 64'h0);
    capture(10);
    check("s2_new7", cap_p0, 64'h7F);
    // write on the exact update edge (cnt=9)
    capture(9);
    check("s2_pre", cap_p0, 64'h7F);
    wr_duty(1'b0, 4'd2);
    capture(1);
    duty_we = 1'b0;
    capture(10);
    check("s2_upd_old", cap_p0, 64'h7F);
    capture(10);
    check("s2_upd_new", cap_p0, 64'h3);

    // 3: limits
    wr_duty(1'b0, 4'd0);
    capture(1);
    wr_duty(1'b1, 4'd10);
    capture(1);
    duty_we = 1'b0;
    capture(8);
    capture(20);
    check("s3_duty0", cap_p0, 64'h0);
    check("s3_dutyfull", cap_p1, 64'hFFFFF);
    check("s3_cs", cap_cs, 64'h00401);
    period_we = 1'b1; period_wdata = 4'd0;
    capture(1);
    period_we = 1'b0;
    capture(9);
    capture(5);
    check("s3_per0_cs", cap_cs, 64'h1F);
    check("s3_per0_p1", cap_p1, 64'h1F);
    check("s3_per0_p0", cap_p0, 64'h0);

    // 4: center mode, period 4, duty ch0 2
    center_mode = 1'b1;
    period_we = 1'b1; period_wdata = 4'd4;
    wr_duty(1'b0, 4'd2);
    capture(1);
    period_we = 1'b0;
    duty_we = 1'b0;
    capture(1);
    capture(16);
    check("s4_p0", cap_p0, 64'h8383);
    check("s4_cs", cap_cs, 64'h0101);
    check("s4_p1", cap_p1, 64'hFFFF);

    // 5: idle levels with polarity, then inverted edge waveform
    en = 1'b0; polarity = 2'b01; center_mode = 1'b0;
    period_we = 1'b1; period_wdata = 4'd9;
    capture(1);
    period_we = 1'b0;
    check("s5_idle_pulse", 64'(pulse), 64'h1);
    check("s5_idle_cs", 64'(cycle_start), 64'h0);
    wr_duty(1'b0, 4'd3);
    capture(1);
    wr_duty(1'b1, 4'd5);
    capture(1);
    duty_we = 1'b0;
    capture(1);
    check("s5_idle_pulse2", 64'(pulse), 64'h1);
    en = 1'b1;
    capture(10);
    check("s5_p0_inv", cap_p0, 64'h3F8);
    check("s5_p1", cap_p1, 64'h1F);
    check("s5_cs", cap_cs, 64'h1);

    // 6: asynchronous reset mid-cycle
    capture(3);
    check("s6_pre_pulse", 64'(pulse), 64'h2);
    #3;
    rst = 1'b1;
    #1;
    check("s6_async_pulse", 64'(pulse), 64'h0);
    check("s6_async_cs", 64'(cycle_start), 64'h0);
    tick();
    check("s6_held_pulse", 64'(pulse), 64'h0);
    rst = 1'b0;
    capture(17);
    check("s6_p0", cap_p0, 64'h1FFFF);
    check("s6_p1", cap_p1, 64'h0);
    check("s6_cs", cap_cs, 64'h10001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Parametrised multi-channel PWM generator. One shared period counter drives NCH channels, each with its own duty comparator and polarity. The block supports edge-aligned and center-aligned counting. Period and duty values are double-buffered (shadow then active), so a software write never produces a glitched or truncated pulse. It sits between the register/switch front-end and LED/motor/pin outputs.

Parameters:
CBITS, 10, counter, period and duty width in bits
NCH, 4, number of PWM output channels (>=1)
SELW, $clog2(NCH) (min 1), width of the channel select bus

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
en  in  1  run enable; low = counter held at 0, outputs idle
center_mode  in  1  0 = edge-aligned, 1 = center-aligned
period_we  in  1  write strobe for the period shadow register
period_wdata  in  CBITS  new period value
duty_we  in  1  write strobe for the duty shadow register
duty_sel  in  SELW  channel index for the duty write
duty_wdata  in  CBITS  new duty value
polarity  in  NCH  per-channel invert; 1 = active-low output
pulse  out  NCH  registered PWM outputs
cycle_start  out  1  registered one-cycle strobe marking the first clock of each PWM cycle

Behaviour:
- Reset (asynchronous, active-high): cnt=0, dir=up, period_sh=period_act=all ones, duty_sh[i]=duty_act[i]=0, pulse=0, cycle_start=0.
- Shadow writes:
  - period_we loads period_sh on the clock edge.
  - duty_we loads duty_sh[duty_sel]. A write with duty_sel>=NCH is ignored.
  - Writes take effect whether or not en is high. Active registers never change except at an update event or while en=0.
- Edge mode: cnt runs 0,1,...,period_act, then wraps to 0. Cycle length is period_act+1 clocks.
- Center mode: cnt counts up 0..period_act, then down period_act-1..1, then 0 again with dir=up. Cycle length is 2*period_act clocks.
  - period_act=0 behaves as edge mode: cnt stays 0, cycle length 1.
  - center_mode is sampled only at an update event; changing it mid-cycle has no effect until the next cycle.
- Update event: the clock edge on which cnt's next value is 0 (start of a new cycle). On that edge, period_act<=period_sh, duty_act<=duty_sh, and the mode is latched.
  - A shadow write on the same edge as an update event lands in the shadow only. The active register takes the old shadow value, and the new value applies one cycle later.
- Outputs (registered, one clock after cnt):
  - pulse[i] <= (cnt < duty_act[i]) XOR polarity[i].
  - cycle_start <= (cnt == 0) && en.
  - duty=0 gives a constant inactive level. Duty > period_act in edge mode, or >= period_act+1 in center mode, gives a constant active level. No glitch at the wrap.
- en=0:
  - cnt forced to 0, dir=up, active registers continuously loaded from the shadows.
  - pulse <= polarity (idle level), cycle_start <= 0.
  - When en rises, the first cycle starts at cnt=0 with the current shadow values.
- Arithmetic: all compares are unsigned, CBITS wide. The counter never exceeds period_act, so no overflow. period_act=2^CBITS-1 is legal.
- Reset mid-operation: outputs go to 0 immediately (asynchronous). Shadow values are lost and restored to the defaults above.

Test Plan:
All scenarios use CBITS=4, NCH=2, polarity=0 unless stated.
1. Reset; write period=9, duty ch0=3; en=1, edge mode. Required: pulse[0] high 3 clocks and low 7 of every 10; cycle_start every 10 clocks, coincident with the pulse[0] rising edge; pulse[1] constant 0.
2. Duty change while cnt=5: write ch0 duty=7. Required: the current cycle stays 3 high; the next cycle is 7 high / 3 low. Write on the exact update edge: the new value appears one cycle later.
3. Limits: duty ch0=0 gives pulse[0]=0 constantly. Duty ch1=10 with period=9 gives pulse[1]=1 constantly, with no low clock at the wrap. period=0 gives cycle_start high every clock.
4. Center mode, period=4, duty ch0=2. Required: cnt sequence 0,1,2,3,4,3,2,1 repeating with an 8-clock cycle; pulse[0] high for 3 clocks per cycle (cnt 0,1 and cnt 1 on the way down).
5. polarity=2'b01, en=0. Required: pulse=2'b01 (idle levels) and cycle_start=0. Raise en: pulse[0] becomes the inverted waveform of scenario 1. Write duty_sel=3 (out of range) on SELW=1 aliasing is not possible; write duty_sel=1 only, and ch0 is unchanged.
6. Assert rst mid-cycle, asynchronously between clock edges. Required: pulse=0 and cycle_start=0 before the next edge. After release with en=1: period=15, duties 0, pulse=polarity.
